// File: rtl/pio_pkg.sv
// Shared constants and helpers for the edge-capturing input PIO.
package pio_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pio_debounce_chan.sv
// One input channel: pin synchroniser followed by a stability filter.
module pio_debounce_chan
    import pio_pkg::*;
#(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 0,
    parameter logic IDLE_BIT        = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic pin_i,
    output logic stable_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;
    logic                   stable_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{IDLE_BIT}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign stable_o = stable_q;

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            always_ff @(posedge clk) begin
                if (reset) begin
                    stable_q <= IDLE_BIT;
                end else begin
                    stable_q <= sync_out;
                end
            end
        end else begin : g_filter
            localparam int CNT_W = clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;
            logic             stable_d;

            // Counter tracks how long the synchronised pin has disagreed with stable.
            always_comb begin
                cnt_d    = cnt_q + 1'b1;
                stable_d = stable_q;
                if (sync_out == stable_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d    = '0;
                    stable_d = sync_out;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_q    <= '0;
                    stable_q <= IDLE_BIT;
                end else begin
                    cnt_q    <= cnt_d;
                    stable_q <= stable_d;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/pio_in_edge_irq.sv
// Avalon-MM input port with per-channel debounce, edge capture and maskable irq.
module pio_in_edge_irq
    import pio_pkg::*;
#(
    parameter int               WIDTH           = 4,
    parameter int               SYNC_STAGES     = 2,
    parameter int               DEBOUNCE_CYCLES = 0,
    parameter int               EDGE_MODE       = 0,
    parameter logic [WIDTH-1:0] IDLE_LEVEL      = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             write,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_prev_q;
    logic [WIDTH-1:0] edge_sel;
    logic [WIDTH-1:0] w1c;
    logic [WIDTH-1:0] edge_q;
    logic [WIDTH-1:0] edge_d;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] mask_d;
    logic [31:0]      readdata_d;
    logic             unused_wdata;

    // Bits of writedata above WIDTH-1 carry no meaning for this port.
    assign unused_wdata = ^writedata;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
            pio_debounce_chan #(
                .SYNC_STAGES    (SYNC_STAGES),
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .IDLE_BIT       (IDLE_LEVEL[gi])
            ) u_chan (
                .clk     (clk),
                .reset   (reset),
                .pin_i   (in_port[gi]),
                .stable_o(stable[gi])
            );
        end
    endgenerate

    always_comb begin
        case (EDGE_MODE)
            EDGE_FALL: edge_sel = ~stable & stable_prev_q;
            EDGE_ANY:  edge_sel = stable ^ stable_prev_q;
            default:   edge_sel = stable & ~stable_prev_q;
        endcase
    end

    // A new edge overrides a same-cycle clear of that bit.
    always_comb begin
        w1c    = (write && (address == ADDR_EDGE)) ? writedata[WIDTH-1:0] : '0;
        edge_d = (edge_q & ~w1c) | edge_sel;
        mask_d = (write && (address == ADDR_MASK)) ? writedata[WIDTH-1:0] : mask_q;
    end

    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_DATA: readdata_d[WIDTH-1:0] = stable;
            ADDR_MASK: readdata_d[WIDTH-1:0] = mask_q;
            ADDR_EDGE: readdata_d[WIDTH-1:0] = edge_q;
            default:   readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stable_prev_q <= IDLE_LEVEL;
            edge_q        <= '0;
            mask_q        <= '0;
            readdata      <= '0;
        end else begin
            stable_prev_q <= stable;
            edge_q        <= edge_d;
            mask_q        <= mask_d;
            readdata      <= readdata_d;
        end
    end

    assign irq = |(edge_q & mask_q);

endmodule

// File: tb/tb_pio_in_edge_irq.sv
// Bench: two configurations (filtered falling-edge, bypass any-edge) against a pin-history model.
module tb_pio_in_edge_irq;

    logic        clk;
    logic        reset;
    logic [1:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] rd_a;
    logic [31:0] rd_b;
    logic        irq_a;
    logic        irq_b;

    int n_checks;
    int n_fail;

    pio_in_edge_irq #(
        .WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(1), .IDLE_LEVEL(4'hF)
    ) dut_a (
        .clk(clk), .reset(reset), .address(address), .write(write),
        .writedata(writedata), .in_port(in_port), .readdata(rd_a), .irq(irq_a)
    );

    pio_in_edge_irq #(
        .WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_MODE(2), .IDLE_LEVEL(4'hF)
    ) dut_b (
        .clk(clk), .reset(reset), .address(address), .write(write),
        .writedata(writedata), .in_port(in_port), .readdata(rd_b), .irq(irq_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: hist[k] is the pin value sampled at edge k; the synchronised value
    // seen at edge k is hist[k-2].
    logic [3:0]  hist [0:4095];
    int          n;
    int          m_deb  [2];
    int          m_mode [2];
    logic [3:0]  m_stab [2];
    logic [3:0]  m_prev [2];
    logic [3:0]  m_cap  [2];
    logic [3:0]  m_mask [2];
    logic [31:0] m_rd   [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [3:0]  ns;
        logic [3:0]  sel;
        logic [3:0]  w1c;
        logic [3:0]  nm;
        logic [31:0] nrd;
        logic        all_diff;
        if (reset) begin
            hist[n]     = 4'hF;
            hist[n - 1] = 4'hF;
        end else begin
            hist[n] = in_port;
        end
        for (int c = 0; c < 2; c++) begin
            if (reset) begin
                m_stab[c] = 4'hF;
                m_prev[c] = 4'hF;
                m_cap[c]  = 4'h0;
                m_mask[c] = 4'h0;
                m_rd[c]   = 32'h0;
            end else begin
                if (m_deb[c] == 0) begin
                    ns = hist[n - 2];
                end else begin
                    ns = m_stab[c];
                    for (int b = 0; b < 4; b++) begin
                        all_diff = 1'b1;
                        for (int k = 2; k <= m_deb[c] + 1; k++) begin
                            if (hist[n - k][b] == m_stab[c][b]) all_diff = 1'b0;
                        end
                        if (all_diff) ns[b] = ~m_stab[c][b];
                    end
                end
                if (m_mode[c] == 0)      sel = m_stab[c] & ~m_prev[c];
                else if (m_mode[c] == 1) sel = ~m_stab[c] & m_prev[c];
                else                     sel = (m_stab[c] & ~m_prev[c]) | (~m_stab[c] & m_prev[c]);
                w1c = (write && address == 2'd3) ? writedata[3:0] : 4'h0;
                nm  = (write && address == 2'd2) ? writedata[3:0] : m_mask[c];
                if (address == 2'd0)      nrd = {28'h0, m_stab[c]};
                else if (address == 2'd2) nrd = {28'h0, m_mask[c]};
                else if (address == 2'd3) nrd = {28'h0, m_cap[c]};
                else                      nrd = 32'h0;
                m_cap[c]  = (m_cap[c] & ~w1c) | sel;
                m_mask[c] = nm;
                m_rd[c]   = nrd;
                m_prev[c] = m_stab[c];
                m_stab[c] = ns;
            end
        end
        n = n + 1;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check("rd_a",  rd_a, m_rd[0]);
        check("rd_b",  rd_b, m_rd[1]);
        check("irq_a", {31'b0, irq_a}, {31'b0, |(m_cap[0] & m_mask[0])});
        check("irq_b", {31'b0, irq_b}, {31'b0, |(m_cap[1] & m_mask[1])});
    endtask

    task automatic cycles(input int k);
        for (int i = 0; i < k; i++) cycle();
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address   = a;
        write     = 1'b1;
        writedata = d;
        $display("write addr=%0d data=%h", a, d);
        cycle();
        write     = 1'b0;
        writedata = 32'h0;
    endtask

    initial begin
        int hold;
        n_checks  = 0;
        n_fail    = 0;
        n         = 8;
        hold      = 0;
        m_deb[0]  = 4; m_mode[0] = 1;
        m_deb[1]  = 0; m_mode[1] = 2;
        for (int i = 0; i < 4096; i++) hist[i] = 4'hF;
        reset     = 1'b1;
        address   = 2'd0;
        write     = 1'b0;
        writedata = 32'h0;
        in_port   = 4'hF;

        cycles(3);
        check("rst_rd",  rd_a, 32'h0);
        check("rst_irq", {31'b0, irq_a}, 32'h0);
        reset = 1'b0;
        cycles(2);
        check("idle_data", rd_a, 32'hF);
        address = 2'd3;
        cycle();
        check("idle_edge", rd_a, 32'h0);
        $display("reset sequence done");

        address = 2'd0;
        in_port = 4'hE;
        cycles(3);
        in_port = 4'hF;
        cycles(10);
        check("glitch_data", rd_a, 32'hF);
        address = 2'd3;
        cycle();
        check("glitch_edge", rd_a, 32'h0);
        $display("glitch sequence done");

        address = 2'd0;
        in_port = 4'hE;
        cycles(6);
        check("press_pre", rd_a, 32'hF);
        cycle();
        check("press_data", rd_a, 32'hE);
        cycles(3);
        address = 2'd3;
        cycle();
        check("press_edge", rd_a, 32'h1);
        check("press_irq0", {31'b0, irq_a}, 32'h0);
        bus_write(2'd2, 32'h1);
        check("mask_irq", {31'b0, irq_a}, 32'h1);

        bus_write(2'd3, 32'h2);
        cycle();
        check("w1c_other", rd_a, 32'h1);
        bus_write(2'd3, 32'h1);
        check("w1c_irq", {31'b0, irq_a}, 32'h0);
        cycle();
        check("w1c_edge", rd_a, 32'h0);
        in_port = 4'hF;
        cycles(10);
        check("release_edge", rd_a, 32'h0);

        bus_write(2'd2, 32'h2);
        in_port = 4'hD;
        cycles(6);
        address   = 2'd3;
        write     = 1'b1;
        writedata = 32'h2;
        $display("write addr=3 data=%h (collision)", writedata);
        cycle();
        write     = 1'b0;
        writedata = 32'h0;
        check("coll_irq", {31'b0, irq_a}, 32'h1);
        cycle();
        check("coll_edge", rd_a, 32'h2);

        in_port = 4'h7;
        cycles(3);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("rst_mid_rd",  rd_a, 32'h0);
        check("rst_mid_irq", {31'b0, irq_a}, 32'h0);
        address = 2'd3;
        cycles(10);
        check("rst_mid_a", rd_a, 32'h8);
        check("rst_mid_b", rd_b, 32'h8);
        address = 2'd0;
        cycles(2);
        in_port = 4'hF;
        cycles(3);
        check("byp_pre",  rd_b, 32'h7);
        cycle();
        check("byp_data", rd_b, 32'hF);
        cycles(8);
        $display("directed sequence done");

        for (int i = 0; i < 500; i++) begin
            if (hold == 0) begin
                in_port = 4'($urandom);
                hold    = int'($urandom_range(1, 8));
            end
            hold      = hold - 1;
            reset     = ($urandom_range(0, 99) == 0);
            write     = ($urandom_range(0, 3) == 0);
            address   = 2'($urandom);
            writedata = $urandom;
            cycle();
        end
        reset = 1'b0;
        write = 1'b0;
        $display("random sequence done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
